load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 33 +++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-RAM bus bundle for the load/store unit.
// slave  : view taken by load_store_unit
// master : view taken by the CPU / RAM side driving the unit
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;

   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores onto a word-wide RAM with
// one-cycle synchronous read. Sub-word stores are read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word and size 2'b11 return rsp_err with no RAM access
//   undefined : addresses are force-aligned, size 2'b11 acts as word, rsp_err stays 0
//
// state  | meaning
// IDLE   | ready for a request (req_ready = 1)
// RD     | word address presented to RAM for a read
// DATA   | RAM data valid: extract load lanes, or merge and write sub-word store
// WR     | full-word store written directly
// RSP    | one-cycle response pulse
module load_store_unit #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   load_store_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_DATA = 3'd2,
      S_WR   = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  acc_err;
   logic [1:0]            acc_size;
   logic [ADDR_WIDTH-1:0] acc_addr;

   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merge_data;

   // Classify the incoming request: alignment handling and error detection
   always_comb begin
      acc_size = bus.req_size;
      acc_addr = bus.req_addr;
      acc_err  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      case (bus.req_size)
         2'b01:   acc_err = bus.req_addr[0];
         2'b10:   acc_err = |bus.req_addr[1:0];
         2'b11:   acc_err = 1'b1;
         default: acc_err = 1'b0;
      endcase
`else
      if (bus.req_size == 2'b11) begin
         acc_size = 2'b10;
      end
      if (acc_size == 2'b01) begin
         acc_addr[0] = 1'b0;
      end else if (acc_size == 2'b10) begin
         acc_addr[1:0] = 2'b00;
      end
`endif
   end

   // Little-endian lane extraction for loads and lane merge for sub-word stores
   always_comb begin
      lane_b     = bus.ram_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h     = bus.ram_rdata[{addr_q[1], 4'b0000} +: 16];
      load_data  = bus.ram_rdata;
      merge_data = bus.ram_rdata;
      case (size_q)
         2'b00: begin
            load_data = {{(DATA_WIDTH-8){~uns_q & lane_b[7]}}, lane_b};
            merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_data = {{(DATA_WIDTH-16){~uns_q & lane_h[15]}}, lane_h};
            merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            load_data  = bus.ram_rdata;
            merge_data = wdata_q;
         end
      endcase
   end

   // RAM strobes decoded from state and registered request only
   always_comb begin
      bus.ram_we    = 1'b0;
      bus.ram_wdata = '0;
      if (state_q == S_WR) begin
         bus.ram_we    = 1'b1;
         bus.ram_wdata = wdata_q;
      end else if (state_q == S_DATA && we_q) begin
         bus.ram_we    = 1'b1;
         bus.ram_wdata = merge_data;
      end
   end

   assign bus.ram_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus.req_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RSP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // Next-state and register-update logic; response regs change only on entry to RSP
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = acc_size;
               uns_d   = bus.req_unsigned;
               addr_d  = acc_addr;
               wdata_d = bus.req_wdata;
               if (acc_err) begin
                  state_d     = S_RSP;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
               end else if (bus.req_we && acc_size == 2'b10) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_DATA;
         end
         S_DATA: begin
            state_d     = S_RSP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? '0 : load_data;
         end
         S_WR: begin
            state_d     = S_RSP;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
         end
         S_RSP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and request registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
